// File: rtl/reset_sequencer_if.sv
// Reset-sequencer bundle: soft reset request, per-stage ready handshake and
// the sequenced active-low stage resets. master = sequencer, slave = consumers.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  soft_reset_in;
  logic [NUM_STAGES-1:0] stage_ready_in;
  logic [NUM_STAGES-1:0] n_stage_reset_out;
  logic                  all_released_out;
  logic                  fault_out;

  modport master (
    input  soft_reset_in,
    input  stage_ready_in,
    output n_stage_reset_out,
    output all_released_out,
    output fault_out
  );

  modport slave (
    output soft_reset_in,
    output stage_ready_in,
    input  n_stage_reset_out,
    input  all_released_out,
    input  fault_out
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES active-low reset domains in order, gated by a hold time,
// a minimum gap and each stage's ready bit. Define RESET_SEQUENCER_TIMEOUT_EN for the ready-timeout fault.
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic               clock_in,
  input  logic               reset_in,
  reset_sequencer_if.master  seq_if
);

  localparam int CNT_MAX_VAL = (1 << CNT_WIDTH) - 1;
  localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);
  localparam logic [CNT_WIDTH-1:0]  HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  GAP_LAST    = CNT_WIDTH'(GAP_CYCLES - 1);

  if ((HOLD_CYCLES > CNT_MAX_VAL) || (GAP_CYCLES > CNT_MAX_VAL) ||
      (TIMEOUT_CYCLES > CNT_MAX_VAL)) begin : g_bad_cnt_width
    $error("reset_sequencer: CNT_WIDTH too small for the cycle parameters");
  end

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES <= GAP_CYCLES) begin : g_bad_timeout
    $error("reset_sequencer: TIMEOUT_CYCLES must exceed GAP_CYCLES");
  end

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_DONE, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_DONE} state_t;
`endif

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    cnt, cnt_nxt, cnt_sat;
  logic [NUM_STAGES-1:0]   n_rst, n_rst_nxt;
  logic                    all_rel, all_nxt;
  logic                    ready_cur;

  // Released bits always form a contiguous prefix, so the most recently
  // released stage is the top bit of that thermometer code.
  assign ready_cur = |(seq_if.stage_ready_in & (n_rst ^ (n_rst >> 1)));
  assign cnt_sat   = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + 1'b1;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  logic fault, fault_nxt;
`endif

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state   <= S_HOLD;
      cnt     <= '0;
      n_rst   <= '0;
      all_rel <= 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
      fault   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      n_rst   <= n_rst_nxt;
      all_rel <= all_nxt;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
      fault   <= fault_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    n_rst_nxt = n_rst;
    all_nxt   = all_rel;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    fault_nxt = fault;
`endif
    if (seq_if.soft_reset_in) begin
      state_nxt = S_HOLD;
      cnt_nxt   = '0;
      n_rst_nxt = '0;
      all_nxt   = 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
      fault_nxt = 1'b0;
`endif
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            n_rst_nxt = FIRST_STAGE;
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        S_WAIT: begin
          cnt_nxt = cnt_sat;
          if ((cnt >= GAP_LAST) && ready_cur) begin
            if (n_rst[NUM_STAGES-1]) begin
              all_nxt   = 1'b1;
              state_nxt = S_DONE;
            end else begin
              n_rst_nxt = (n_rst << 1) | FIRST_STAGE;
              cnt_nxt   = '0;
            end
          end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          else if (cnt >= TIMEOUT_LAST) begin
            fault_nxt = 1'b1;
            state_nxt = S_FAULT;
          end
`endif
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  assign seq_if.n_stage_reset_out = n_rst;
  assign seq_if.all_released_out  = all_rel;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
  assign seq_if.fault_out = fault;
`else
  assign seq_if.fault_out = 1'b0;
`endif

endmodule
